tile_sprite_renderer: RTL and testbench
=======================================

Name: tile_sprite_renderer

Overview:
Parametrised successor to the fixed 16x16 tile drawer. On a start strobe it latches one grid cell address and its 8-bit cell content. It then raster-scans the whole tile, emitting one pixel per cycle (x, y, colour, plot) to the VGA frame-buffer writer. Cell content selects the shape: wall, tank1, tank2 with direction-dependent gun, projectile, or background clear. Drives the per-cell draw loop under the game-board refresh FSM.

Parameters:
TILE_LOG2, 4, log2 of tile edge in pixels (tile is 2^TILE_LOG2 square)
COL_BITS, 4, grid column index width
ROW_BITS, 4, grid row index width
COLOUR_W, 3, colour width
TANK_W, 8, tank body edge in pixels, even, < tile edge
PROJ_W, 2, projectile edge in pixels, even, <= TANK_W

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request to draw one cell; sampled only when busy=0
address  in  COL_BITS+ROW_BITS  [COL_BITS-1:0]=column, upper bits=row
position  in  8  cell content: bit7 wall, bit6 tank1, bit5 tank2, bit4 projectile, bits1:0 direction
stall  in  1  frame-buffer backpressure; freezes scan
x  out  COL_BITS+TILE_LOG2  pixel x
y  out  ROW_BITS+TILE_LOG2  pixel y
colour  out  COLOUR_W  pixel colour
plot  out  1  pixel valid / write enable
busy  out  1  draw in progress
done  out  1  one-cycle pulse after last pixel

Behaviour:
- Reset (async, any time, including mid-draw): state IDLE; x, y, colour, counter = 0; plot, busy, done = 0. No done is issued for an aborted draw.
- States: IDLE -> DRAW -> FINISH -> IDLE.
- IDLE: on start=1, latch address and position, clear pixel counter N = 0, go to DRAW, busy=1 next cycle. start is ignored while busy=1.
- DRAW, stall=0: registered outputs present pixel N. px = N[TILE_LOG2-1:0], py = N[2*TILE_LOG2-1:TILE_LOG2], so x runs fastest. x = col*2^TILE_LOG2 + px, y = row*2^TILE_LOG2 + py, plot=1, N increments.
- DRAW, stall=1: N holds, plot=0, and x, y, colour hold their last values.
- Timing with no stall: pixel n is on the outputs in cycle n+1 after the start-accept cycle. After pixel 2^(2*TILE_LOG2)-1 the block enters FINISH.
- FINISH: done=1 and plot=0 for exactly one cycle; busy drops in the same cycle; return to IDLE. A new start is accepted from the following cycle. Minimum cell period is 2^(2*TILE_LOG2)+2 cycles.
- Shape type is decoded from the latched position, priority wall > tank1 > tank2 > projectile > empty. Any other or zero value means empty.
- Per-pixel colour for a tile of edge T = 2^TILE_LOG2, with c = T/2:
  - Wall: every pixel WALL_C (3'b011).
  - Tank1 / tank2: body is px and py in [c-TANK_W/2, c+TANK_W/2-1]. The gun is a 2-pixel stripe (cols or rows c-1..c) running from the body edge to the tile edge.
    - Direction 00 = up (py < body top).
    - 01 = down (py > body bottom).
    - 10 = left (px < body left).
    - 11 = right (px > body right).
    - Body and gun use TANK1_C (3'b101) or TANK2_C (3'b001).
  - Projectile: px and py in [c-PROJ_W/2, c+PROJ_W/2-1] use PROJ_C (3'b110).
  - All other pixels, and the empty type, use BG_C (3'b000). Every plotted tile is therefore fully overwritten.
- All coordinate arithmetic is a concatenation {col, px} / {row, py}, so no overflow is possible.
- Direction bits are ignored for non-tank types.

Decomposition:
- Package tile_render_pkg holds:
  - type enum (T_EMPTY, T_WALL, T_TANK1, T_TANK2, T_PROJ)
  - direction codes (DIR_UP=2'b00, DIR_DOWN=2'b01, DIR_LEFT=2'b10, DIR_RIGHT=2'b11)
  - position bit indices
  - colour constants (WALL_C, TANK1_C, TANK2_C, PROJ_C, BG_C)
- One sub-module, tile_shape_colour: combinational (type, dir, px, py) -> colour, parametrised by TILE_LOG2, TANK_W and PROJ_W. The top module holds the FSM, counter and output registers.

Test Plan:
1. Defaults, address=8'h23, position=8'h80, start for 1 cycle -> 256 plots, first (48,32), last (63,47), all colour 3'b011; done pulses once in cycle 257 after accept; busy high in cycles 1..257.
2. position=8'h40 (tank1 up), address=8'h00 -> (4,4) and (11,11) = 3'b101; gun (7,0) and (8,3) = 3'b101; (0,0), (6,0) and (7,12) = 3'b000.
3. position=8'h23 (tank2 right), address=8'h00 -> (15,7) = 3'b001, (0,7) = 3'b000, (7,15) = 3'b000; position=8'h90 (wall+proj) draws all-wall 3'b011.
4. position=8'h10 -> only (7,7), (8,7), (7,8), (8,8) = 3'b110; the remaining 252 pixels = 3'b000. position=8'h00 -> 256 plots of 3'b000.
5. stall high for 5 cycles at pixel 100; start pulsed mid-draw -> 256 plots total, no repeat or skip, x/y held during stall, done at cycle 262, second start ignored.
6. reset asserted at pixel 50 -> outputs 0 asynchronously, no done; next start after reset draws a complete tile from pixel 0.

Source files
------------

// File: rtl/tile_sprite_renderer_pkg.sv
// ============================================================================
//  Module      : tile_render_pkg
//  Description : Shared types, direction codes, position bit map and colours
//                for the tile/sprite renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tile_render_pkg;

    typedef enum logic [2:0] {
        T_EMPTY = 3'd0,
        T_WALL  = 3'd1,
        T_TANK1 = 3'd2,
        T_TANK2 = 3'd3,
        T_PROJ  = 3'd4
    } shape_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int POS_WALL    = 7;
    localparam int POS_TANK1   = 6;
    localparam int POS_TANK2   = 5;
    localparam int POS_PROJ    = 4;
    localparam int POS_DIR_LSB = 0;

    localparam logic [2:0] WALL_C  = 3'b011;
    localparam logic [2:0] TANK1_C = 3'b101;
    localparam logic [2:0] TANK2_C = 3'b001;
    localparam logic [2:0] PROJ_C  = 3'b110;
    localparam logic [2:0] BG_C    = 3'b000;

    // Priority wall > tank1 > tank2 > projectile; anything else is empty.
    function automatic shape_t decode_shape(input logic [7:0] position);
        shape_t shape;
        shape = T_EMPTY;
        if (position[POS_WALL])       shape = T_WALL;
        else if (position[POS_TANK1]) shape = T_TANK1;
        else if (position[POS_TANK2]) shape = T_TANK2;
        else if (position[POS_PROJ])  shape = T_PROJ;
        return shape;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tile_sprite_renderer_if.sv
// ============================================================================
//  Module      : tile_sprite_renderer_if
//  Description : Cell request / pixel stream bundle between the board refresh
//                controller (master) and the renderer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tile_sprite_renderer_if #(
    parameter int COL_BITS  = 4,
    parameter int ROW_BITS  = 4,
    parameter int TILE_LOG2 = 4,
    parameter int COLOUR_W  = 3
) ();
    logic                          start;
    logic [COL_BITS+ROW_BITS-1:0]  address;
    logic [7:0]                    position;
    logic                          stall;
    logic [COL_BITS+TILE_LOG2-1:0] x;
    logic [ROW_BITS+TILE_LOG2-1:0] y;
    logic [COLOUR_W-1:0]           colour;
    logic                          plot;
    logic                          busy;
    logic                          done;

    modport master (
        output start, address, position, stall,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, address, position, stall,
        output x, y, colour, plot, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/tile_sprite_renderer_shape_colour.sv
// ============================================================================
//  Module      : tile_shape_colour
//  Description : Combinational pixel colour for one shape at tile-local (px,py).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_shape_colour
    import tile_render_pkg::*;
#(
    parameter int TILE_LOG2 = 4,
    parameter int TANK_W    = 8,
    parameter int PROJ_W    = 2
) (
    input  shape_t               shape,
    input  logic [1:0]           dir,
    input  logic [TILE_LOG2-1:0] px,
    input  logic [TILE_LOG2-1:0] py,
    output logic [2:0]           colour
);
    localparam int c_centre = 2 ** (TILE_LOG2 - 1);
    localparam logic [TILE_LOG2-1:0] c_body_lo = TILE_LOG2'(c_centre - TANK_W / 2);
    localparam logic [TILE_LOG2-1:0] c_body_hi = TILE_LOG2'(c_centre + TANK_W / 2 - 1);
    localparam logic [TILE_LOG2-1:0] c_gun_lo  = TILE_LOG2'(c_centre - 1);
    localparam logic [TILE_LOG2-1:0] c_gun_hi  = TILE_LOG2'(c_centre);
    localparam logic [TILE_LOG2-1:0] c_proj_lo = TILE_LOG2'(c_centre - PROJ_W / 2);
    localparam logic [TILE_LOG2-1:0] c_proj_hi = TILE_LOG2'(c_centre + PROJ_W / 2 - 1);

    logic w_in_body;
    logic w_gun_col;
    logic w_gun_row;
    logic w_gun;
    logic w_in_proj;

    assign w_in_body = (px >= c_body_lo) && (px <= c_body_hi) &&
                       (py >= c_body_lo) && (py <= c_body_hi);
    assign w_gun_col = (px >= c_gun_lo) && (px <= c_gun_hi);
    assign w_gun_row = (py >= c_gun_lo) && (py <= c_gun_hi);
    assign w_in_proj = (px >= c_proj_lo) && (px <= c_proj_hi) &&
                       (py >= c_proj_lo) && (py <= c_proj_hi);

    // Gun stripe runs from the body edge out to the tile edge.
    always_comb begin
        w_gun = 1'b0;
        case (dir)
            DIR_UP:    w_gun = (py < c_body_lo) && w_gun_col;
            DIR_DOWN:  w_gun = (py > c_body_hi) && w_gun_col;
            DIR_LEFT:  w_gun = (px < c_body_lo) && w_gun_row;
            DIR_RIGHT: w_gun = (px > c_body_hi) && w_gun_row;
            default:   w_gun = 1'b0;
        endcase
    end

    always_comb begin
        colour = BG_C;
        case (shape)
            T_WALL:  colour = WALL_C;
            T_TANK1: if (w_in_body || w_gun) colour = TANK1_C;
            T_TANK2: if (w_in_body || w_gun) colour = TANK2_C;
            T_PROJ:  if (w_in_proj) colour = PROJ_C;
            default: colour = BG_C;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tile_sprite_renderer.sv
// ============================================================================
//  Module      : tile_sprite_renderer
//  Description : Latches one grid cell and raster-scans its tile, one pixel
//                per cycle, with stall support and a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_sprite_renderer
    import tile_render_pkg::*;
#(
    parameter int TILE_LOG2 = 4,
    parameter int COL_BITS  = 4,
    parameter int ROW_BITS  = 4,
    parameter int COLOUR_W  = 3,
    parameter int TANK_W    = 8,
    parameter int PROJ_W    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    tile_sprite_renderer_if.slave  bus
);
    localparam int c_n_w = 2 * TILE_LOG2;
    localparam logic [c_n_w:0] c_cnt_one = (c_n_w + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAW   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                        r_state;
    logic [c_n_w:0]                r_cnt;
    logic [COL_BITS-1:0]           r_col;
    logic [ROW_BITS-1:0]           r_row;
    shape_t                        r_shape;
    logic [1:0]                    r_dir;
    logic [COL_BITS+TILE_LOG2-1:0] r_x;
    logic [ROW_BITS+TILE_LOG2-1:0] r_y;
    logic [COLOUR_W-1:0]           r_colour;
    logic                          r_plot;
    logic                          r_busy;
    logic                          r_done;

    logic                 w_idle;
    logic [COL_BITS-1:0]  w_col;
    logic [ROW_BITS-1:0]  w_row;
    shape_t               w_shape;
    logic [1:0]           w_dir;
    logic [c_n_w-1:0]     w_n;
    logic [TILE_LOG2-1:0] w_px;
    logic [TILE_LOG2-1:0] w_py;
    logic [2:0]           w_colour;

    // Pixel 0 is registered in the accept cycle, so the shape path looks at
    // the live request while idle and at the latched cell otherwise.
    assign w_idle  = (r_state == S_IDLE);
    assign w_col   = w_idle ? bus.address[COL_BITS-1:0] : r_col;
    assign w_row   = w_idle ? bus.address[COL_BITS+ROW_BITS-1:COL_BITS] : r_row;
    assign w_shape = w_idle ? decode_shape(bus.position) : r_shape;
    assign w_dir   = w_idle ? bus.position[POS_DIR_LSB +: 2] : r_dir;
    assign w_n     = w_idle ? '0 : r_cnt[c_n_w-1:0];
    assign w_px    = w_n[TILE_LOG2-1:0];
    assign w_py    = w_n[c_n_w-1:TILE_LOG2];

    tile_shape_colour #(
        .TILE_LOG2 (TILE_LOG2),
        .TANK_W    (TANK_W),
        .PROJ_W    (PROJ_W)
    ) u_shape (
        .shape  (w_shape),
        .dir    (w_dir),
        .px     (w_px),
        .py     (w_py),
        .colour (w_colour)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_shape  <= T_EMPTY;
            r_dir    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_plot <= 1'b0;
                    if (bus.start) begin
                        r_state  <= S_DRAW;
                        r_col    <= w_col;
                        r_row    <= w_row;
                        r_shape  <= w_shape;
                        r_dir    <= w_dir;
                        r_x      <= {w_col, w_px};
                        r_y      <= {w_row, w_py};
                        r_colour <= COLOUR_W'(w_colour);
                        r_plot   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= c_cnt_one;
                    end
                end
                S_DRAW: begin
                    // Top counter bit set means the last pixel is already out.
                    if (r_cnt[c_n_w]) begin
                        r_state <= S_FINISH;
                        r_plot  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (bus.stall) begin
                        r_plot <= 1'b0;
                    end else begin
                        r_x      <= {w_col, w_px};
                        r_y      <= {w_row, w_py};
                        r_colour <= COLOUR_W'(w_colour);
                        r_plot   <= 1'b1;
                        r_cnt    <= r_cnt + c_cnt_one;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_plot  <= 1'b0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_plot  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.colour = r_colour;
    assign bus.plot   = r_plot;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tile_sprite_renderer.sv
// ============================================================================
//  Module      : tb_tile_sprite_renderer
//  Description : Self-checking bench for tile_sprite_renderer (default sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_sprite_renderer;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } px_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] pos;
        int         px;
        int         py;
        logic [2:0] col;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    px_t  sb[$];
    vec_t tbl[$];
    logic [2:0] cap [16][16];

    tile_sprite_renderer_if #(.COL_BITS(4), .ROW_BITS(4), .TILE_LOG2(4), .COLOUR_W(3)) bus ();

    tile_sprite_renderer #(
        .TILE_LOG2 (4), .COL_BITS (4), .ROW_BITS (4),
        .COLOUR_W  (3), .TANK_W   (8), .PROJ_W   (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference picture for the default 16x16 tile, 8-pixel tank, 2-pixel shot.
    function automatic logic [2:0] model(input logic [7:0] p, input int px, input int py);
        bit body, gun, cv, cr;
        if (p[7]) return 3'b011;
        if (p[6] || p[5]) begin
            body = (px >= 4 && px <= 11 && py >= 4 && py <= 11);
            cv   = (px == 7 || px == 8);
            cr   = (py == 7 || py == 8);
            case (p[1:0])
                2'b00:   gun = (py < 4) && cv;
                2'b01:   gun = (py > 11) && cv;
                2'b10:   gun = (px < 4) && cr;
                default: gun = (px > 11) && cr;
            endcase
            if (!(body || gun)) return 3'b000;
            return p[6] ? 3'b101 : 3'b001;
        end
        if (p[4]) return (cv_in(px) && cv_in(py)) ? 3'b110 : 3'b000;
        return 3'b000;
    endfunction

    function automatic bit cv_in(input int v);
        return (v == 7 || v == 8);
    endfunction

    task automatic draw_cell(input logic [7:0] a, input logic [7:0] p, input int stall_at,
                             input int stall_len, input int mid_at, input int abort_at);
        int k, plots, done_k, exp_done, late_done;
        logic busy_ok, hold_ok;
        logic [7:0] lx, ly;
        px_t e;
        exp_done = 257 + ((stall_at > 0) ? stall_len : 0);
        sb.delete();
        for (int py = 0; py < 16; py++)
            for (int px = 0; px < 16; px++)
                sb.push_back('{{a[3:0], 4'(px)}, {a[7:4], 4'(py)}, model(p, px, py)});
        @(negedge clock);
        bus.address  = a;
        bus.position = p;
        bus.start    = 1'b1;
        k = 0; plots = 0; done_k = 0; busy_ok = 1'b1; hold_ok = 1'b1; lx = '0; ly = '0;
        while (k < 400 && done_k == 0) begin
            @(negedge clock);
            k++;
            bus.start    = (k == mid_at);
            bus.position = (k == mid_at) ? 8'h10 : p;
            if (abort_at > 0 && k == abort_at) begin
                reset = 1'b1;
                #1;
                check("reset_async", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 0);
                late_done = 0;
                repeat (3) begin
                    @(negedge clock);
                    if (bus.done) late_done++;
                end
                check("no_done_after_abort", late_done, 0);
                reset     = 1'b0;
                bus.start = 1'b0;
                bus.stall = 1'b0;
                sb.delete();
                return;
            end
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.plot) begin
                if (sb.size() == 0) begin
                    check("extra_pixel", {bus.x, bus.y}, 0);
                end else begin
                    e = sb.pop_front();
                    check("pixel", {bus.x, bus.y, bus.colour}, {e.x, e.y, e.c});
                end
                cap[bus.x[3:0]][bus.y[3:0]] = bus.colour;
                lx = bus.x; ly = bus.y;
                plots++;
            end else if (!bus.done && plots > 0 && (bus.x != lx || bus.y != ly)) begin
                hold_ok = 1'b0;
            end
            if (bus.done) done_k = k;
            if (k == stall_at) bus.stall = 1'b1;
            if (k == stall_at + stall_len) bus.stall = 1'b0;
        end
        bus.stall = 1'b0;
        check("done_cycle", done_k, exp_done);
        check("plot_count", plots, 256);
        check("scoreboard_empty", sb.size(), 0);
        check("busy_during_draw", busy_ok, 1);
        check("xy_hold_on_stall", hold_ok, 1);
        @(negedge clock);
        check("idle_after_done", {bus.busy, bus.done, bus.plot}, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.address = '0; bus.position = '0; bus.stall = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_state", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 0);
        reset = 1'b0;
        @(negedge clock);

        tbl.push_back('{8'h23, 8'h80,  0,  0, 3'b011});
        tbl.push_back('{8'h23, 8'h80, 15, 15, 3'b011});
        tbl.push_back('{8'h00, 8'h40,  4,  4, 3'b101});
        tbl.push_back('{8'h00, 8'h40, 11, 11, 3'b101});
        tbl.push_back('{8'h00, 8'h40,  7,  0, 3'b101});
        tbl.push_back('{8'h00, 8'h40,  8,  3, 3'b101});
        tbl.push_back('{8'h00, 8'h40,  0,  0, 3'b000});
        tbl.push_back('{8'h00, 8'h40,  6,  0, 3'b000});
        tbl.push_back('{8'h00, 8'h40,  7, 12, 3'b000});
        tbl.push_back('{8'h00, 8'h23, 15,  7, 3'b001});
        tbl.push_back('{8'h00, 8'h23,  0,  7, 3'b000});
        tbl.push_back('{8'h00, 8'h23,  7, 15, 3'b000});
        tbl.push_back('{8'h00, 8'h90,  5,  5, 3'b011});
        tbl.push_back('{8'h00, 8'h10,  7,  7, 3'b110});
        tbl.push_back('{8'h00, 8'h10,  8,  8, 3'b110});
        tbl.push_back('{8'h00, 8'h10,  6,  7, 3'b000});
        tbl.push_back('{8'h00, 8'h00,  3,  3, 3'b000});
        tbl.push_back('{8'h00, 8'h41,  7, 15, 3'b101});
        tbl.push_back('{8'h00, 8'h41,  7,  0, 3'b000});
        tbl.push_back('{8'h00, 8'h42,  0,  7, 3'b101});
        tbl.push_back('{8'h00, 8'h60,  7,  0, 3'b101});

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 0 || tbl[i].addr != tbl[i-1].addr || tbl[i].pos != tbl[i-1].pos)
                draw_cell(tbl[i].addr, tbl[i].pos, 0, 0, 0, 0);
            check($sformatf("vec%0d_colour", i), cap[tbl[i].px][tbl[i].py], tbl[i].col);
        end

        // Stall burst plus an ignored mid-draw start.
        draw_cell(8'h5A, 8'h22, 101, 5, 150, 0);
        // Abort at pixel 50, then a full redraw of the same cell.
        draw_cell(8'hF1, 8'h80, 0, 0, 0, 51);
        draw_cell(8'hF1, 8'h33, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
